// File: rtl/writeback_arbiter.sv
// Register-file write-port arbiter: pipeline results vs. a FIFO of long-latency results,
// with an optional RAW scoreboard enabled by defining WB_SCOREBOARD_EN.
module writeback_arbiter #(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          pipe_valid,
  output logic                          pipe_ready,
  input  logic [4:0]                    pipe_addr,
  input  logic [31:0]                   pipe_data,
  input  logic                          lsu_valid,
  output logic                          lsu_ready,
  input  logic [4:0]                    lsu_addr,
  input  logic [31:0]                   lsu_data,
  input  logic                          issue_valid,
  input  logic [4:0]                    issue_addr,
  input  logic [4:0]                    chk_addr1,
  input  logic [4:0]                    chk_addr2,
  output logic                          hazard,
  output logic                          rf_write_enable,
  output logic [4:0]                    rf_write_address,
  output logic [31:0]                   rf_write_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]    mem_addr [FIFO_DEPTH];
  logic [31:0]   mem_data [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q;
  logic [SW-1:0] starve_cnt_q, starve_cnt_d;

  logic        fifo_empty, fifo_full, starve;
  logic        push, pop, pipe_win, sel_valid;
  logic [4:0]  head_addr, sel_addr;
  logic [31:0] head_data, sel_data;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign starve     = !fifo_empty && (starve_cnt_q == SW'(STARVE_LIMIT));
  assign pipe_ready = !starve;
  assign lsu_ready  = !fifo_full;
  assign fifo_count = count_q;

  assign head_addr = mem_addr[rd_ptr_q];
  assign head_data = mem_data[rd_ptr_q];

  // The FIFO wins when forced by starvation or when the pipeline has nothing to write.
  assign push      = lsu_valid && lsu_ready;
  assign pop       = !fifo_empty && (starve || !pipe_valid);
  assign pipe_win  = pipe_valid && !starve;
  assign sel_valid = pop || pipe_win;

  always_comb begin
    sel_addr = pipe_addr;
    sel_data = pipe_data;
    if (pop) begin
      sel_addr = head_addr;
      sel_data = head_data;
    end
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (fifo_empty || pop) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != SW'(STARVE_LIMIT)) begin
      starve_cnt_d = starve_cnt_q + SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr_q] <= lsu_addr;
      mem_data[wr_ptr_q] <= lsu_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q         <= '0;
      wr_ptr_q         <= '0;
      count_q          <= '0;
      starve_cnt_q     <= '0;
      rf_write_enable  <= 1'b0;
      rf_write_address <= '0;
      rf_write_data    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q         <= count_q + CW'(push) - CW'(pop);
      starve_cnt_q    <= starve_cnt_d;
      // x0 writes are consumed but never reach the register file.
      rf_write_enable <= sel_valid && (sel_addr != 5'd0);
      if (sel_valid) begin
        rf_write_address <= sel_addr;
        rf_write_data    <= sel_data;
      end
    end
  end

`ifdef WB_SCOREBOARD_EN
  logic [31:0] busy_q, busy_d;

  always_comb begin
    busy_d = busy_q;
    if (pop) busy_d[head_addr] = 1'b0;
    // Applied after the clear so a same-cycle issue keeps the register busy.
    if (issue_valid) busy_d[issue_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign hazard = ((chk_addr1 != 5'd0) && busy_q[chk_addr1]) ||
                  ((chk_addr2 != 5'd0) && busy_q[chk_addr2]);
`else
  logic unused_sb;
  assign unused_sb = ^{issue_valid, issue_addr, chk_addr1, chk_addr2};
  assign hazard    = 1'b0;
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Randomized scoreboard bench for writeback_arbiter against a queue-based reference model.
module tb_writeback_arbiter;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_valid, pipe_ready, lsu_valid, lsu_ready, issue_valid, hazard;
  logic [4:0]  pipe_addr, lsu_addr, issue_addr, chk_addr1, chk_addr2, rf_write_address;
  logic [31:0] pipe_data, lsu_data, rf_write_data;
  logic        rf_write_enable;
  logic [2:0]  fifo_count;

  always #5 clk = ~clk;

  writeback_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .pipe_valid(pipe_valid), .pipe_ready(pipe_ready), .pipe_addr(pipe_addr),
    .pipe_data(pipe_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_addr(lsu_addr), .lsu_data(lsu_data),
    .issue_valid(issue_valid), .issue_addr(issue_addr),
    .chk_addr1(chk_addr1), .chk_addr2(chk_addr2), .hazard(hazard),
    .rf_write_enable(rf_write_enable), .rf_write_address(rf_write_address),
    .rf_write_data(rf_write_data), .fifo_count(fifo_count)
  );

  typedef struct {logic we; logic [4:0] a; logic [31:0] d;} wr_t;
  typedef struct {logic [4:0] a; logic [31:0] d;} ent_t;

  wr_t  exp_q[$];
  ent_t m_fifo[$];
  int   m_starve;
  bit   m_busy[32];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_fifo.delete();
    m_starve = 0;
    foreach (m_busy[i]) m_busy[i] = 1'b0;
  endtask

  // One cycle: drive at the falling edge, check combinational outputs, advance the model.
  task automatic step(input logic pv, input logic [4:0] pa, input logic [31:0] pd,
                      input logic lv, input logic [4:0] la, input logic [31:0] ld,
                      input logic iv, input logic [4:0] ia,
                      input logic [4:0] c1, input logic [4:0] c2);
    bit   starve, lrdy, popped, nonempty, exp_haz;
    wr_t  e;
    ent_t h;
    ent_t n;
    @(negedge clk);
    pipe_valid = pv; pipe_addr = pa; pipe_data = pd;
    lsu_valid = lv; lsu_addr = la; lsu_data = ld;
    issue_valid = iv; issue_addr = ia; chk_addr1 = c1; chk_addr2 = c2;
    #1;
    nonempty = m_fifo.size() > 0;
    starve   = nonempty && (m_starve == LIMIT);
    lrdy     = m_fifo.size() < DEPTH;
`ifdef WB_SCOREBOARD_EN
    exp_haz  = (c1 != 0 && m_busy[c1]) || (c2 != 0 && m_busy[c2]);
`else
    exp_haz  = 1'b0;
`endif
    chk("pipe_ready", pipe_ready, !starve);
    chk("lsu_ready", lsu_ready, lrdy);
    chk("fifo_count", fifo_count, m_fifo.size());
    chk("hazard", hazard, exp_haz);

    popped = 1'b0;
    e.we = 1'b0; e.a = '0; e.d = '0;
    h.a = '0; h.d = '0;
    if (nonempty && (starve || !pv)) begin
      h = m_fifo.pop_front();
      popped = 1'b1;
      e.we = (h.a != 0); e.a = h.a; e.d = h.d;
    end else if (pv) begin
      e.we = (pa != 0); e.a = pa; e.d = pd;
    end
    exp_q.push_back(e);

    if (!nonempty || popped) m_starve = 0;
    else if (m_starve < LIMIT) m_starve++;
    if (popped) m_busy[h.a] = 1'b0;
    if (iv && ia != 0) m_busy[ia] = 1'b1;
    if (lv && lrdy) begin
      n.a = la; n.d = ld;
      m_fifo.push_back(n);
    end
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    pipe_valid = 0; lsu_valid = 0; issue_valid = 0;
    #1;
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_hazard", hazard, 0);
    chk("rst_we", rf_write_enable, 0);
    chk("rst_lsu_ready", lsu_ready, 1);
    chk("rst_pipe_ready", pipe_ready, 1);
    model_clear();
    @(negedge clk);
    #1 rst = 1'b0;
  endtask

  // Monitor: one expected write-port state per cycle, observed at the falling edge.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("rf_we", rf_write_enable, e.we);
          if (e.we) begin
            chk("rf_addr", rf_write_address, e.a);
            chk("rf_data", rf_write_data, e.d);
          end
        end else begin
          chk("idle_we", rf_write_enable, 0);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    pipe_valid = 0; pipe_addr = 0; pipe_data = 0;
    lsu_valid = 0; lsu_addr = 0; lsu_data = 0;
    issue_valid = 0; issue_addr = 0; chk_addr1 = 0; chk_addr2 = 0;
    model_clear();
    #1;
    chk("init_we", rf_write_enable, 0);
    chk("init_addr", rf_write_address, 0);
    chk("init_data", rf_write_data, 0);
    chk("init_fifo_count", fifo_count, 0);
    chk("init_lsu_ready", lsu_ready, 1);
    chk("init_pipe_ready", pipe_ready, 1);
    chk("init_hazard", hazard, 0);
    @(negedge clk);
    #1 rst = 1'b0;

    // Single pipeline write, then nothing.
    step(1, 5, 32'h1234, 0, 0, 0, 0, 0, 0, 0);
    idle();

    // Issue x7, see the hazard, then the LSU result clears it.
    step(0, 0, 0, 0, 0, 0, 1, 7, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 7, 0);
    step(0, 0, 0, 1, 7, 32'hCAFE, 0, 0, 7, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 7, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 7, 0);

    // Fill the FIFO under continuous pipeline traffic until starvation forces a pop.
    for (int i = 0; i < 4; i++) step(1, 5'(i + 1), 32'(i), 1, 5'(10 + i), 32'(100 + i), 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(1, 2, 32'(200 + i), 1, 20, 32'(300 + i), 0, 0, 0, 0);
    repeat (8) idle();

    // Writes to x0 from both sources.
    step(1, 0, 32'hDEAD, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 32'hBEEF, 0, 0, 0, 0);
    idle();
    idle();

    // Re-issue x9 in the cycle its FIFO entry is written.
    step(0, 0, 0, 1, 9, 32'h99, 1, 9, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 9, 0, 9);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 9);
    idle();

    // Asynchronous reset with FIFO entries and a busy register.
    step(1, 1, 1, 1, 3, 32'h33, 1, 3, 3, 0);
    step(1, 2, 2, 1, 4, 32'h44, 0, 0, 3, 0);
    do_reset();

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      step($urandom_range(0, 9) < 7, 5'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 9) < 5, 5'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 3) == 0, 5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    repeat (10) idle();
    @(negedge clk);
    #2;
    chk("exp_q_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/writeback_arbiter.md
# writeback_arbiter

Single-port writer for the 32-entry register file: merges single-cycle pipeline results with long-latency load/multiply results and drives the file's one write port. Long-latency results are buffered in a small FIFO. A per-register scoreboard marks destinations of in-flight long-latency ops so decode can stall on RAW hazards. The block sits between the execute/writeback stage and the register file write port. The register file samples the write port on the falling edge of the same cycle.

## Interface
Parameters:
- FIFO_DEPTH, 4: long-latency result FIFO entries; power of two, ≥2
- STARVE_LIMIT, 4: consecutive cycles a non-empty FIFO may lose arbitration before it is forced to win

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- pipe_valid  in  1  pipeline writeback request
- pipe_ready  out  1  pipeline request accepted this cycle (combinational)
- pipe_addr  in  5  pipeline destination register
- pipe_data  in  32  pipeline result
- lsu_valid  in  1  long-latency result valid
- lsu_ready  out  1  FIFO can accept (= not full)
- lsu_addr  in  5  long-latency destination register
- lsu_data  in  32  long-latency result
- issue_valid  in  1  long-latency op issued; mark issue_addr busy
- issue_addr  in  5  destination of issued op
- chk_addr1  in  5  decode source register 1
- chk_addr2  in  5  decode source register 2
- hazard  out  1  either nonzero chk address is busy (combinational)
- rf_write_enable  out  1  register file write enable (registered)
- rf_write_address  out  5  register file write address (registered)
- rf_write_data  out  32  register file write data (registered)
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

## Operation
- Arbitration happens each cycle. Pipeline has priority unless the starve condition holds: FIFO non-empty and starve_cnt == STARVE_LIMIT.
- pipe_ready = !starve.
- If the starve condition holds, the FIFO head is popped and written.
- Otherwise, if pipe_valid, the pipeline result is written.
- Otherwise, if the FIFO is non-empty, the head is popped and written.
- Otherwise nothing is written.
- Address 0: the selected entry is consumed and the FIFO pops, but rf_write_enable is 0.
- starve_cnt:
  - increments when the FIFO is non-empty and the pipeline wins
  - resets to 0 when the FIFO pops or is empty
  - saturates at STARVE_LIMIT
- FIFO push occurs on lsu_valid && lsu_ready.
  - Push and pop may occur together; count is unchanged.
  - A full FIFO does not accept in a cycle it also pops, because lsu_ready depends only on registered count.
- Scoreboard: 32 busy bits; bit 0 is always 0.
  - Set on issue_valid with issue_addr ≠ 0.
  - Cleared when a FIFO entry for that address is written.
  - Simultaneous set and clear of the same register: set wins.
  - Pipeline writes never clear busy bits. Decode must stall on hazard, so a pipeline write to a busy register is a pipeline error and is not checked.
- hazard = (chk_addr1≠0 && busy[chk_addr1]) || (chk_addr2≠0 && busy[chk_addr2]).

## Timing
- A request selected in cycle k appears on rf_write_* in cycle k+1. The register file commits it on the falling edge of cycle k+1.
- The FIFO pop and the busy clear take effect at the same rising edge that loads rf_write_*.
- Minimum LSU latency: accepted at edge k, written to rf_write_* at edge k+1 if the pipeline is idle.
- Worst-case FIFO head wait under continuous pipe_valid is STARVE_LIMIT+1 cycles.
- Reset values:
  - rf_write_enable=0, rf_write_address=0, rf_write_data=0
  - FIFO empty, fifo_count=0, lsu_ready=1
  - all busy bits 0, starve_cnt=0, pipe_ready=1, hazard=0
- Reset mid-operation discards FIFO contents and the scoreboard immediately (asynchronous).
- rf_write_enable drops in the same cycle reset asserts.

## Configuration
- WB_SCOREBOARD_EN defined: scoreboard present as described.
- WB_SCOREBOARD_EN undefined: no busy bits; hazard tied 0; issue_valid, issue_addr, chk_addr1 and chk_addr2 are ignored. Arbitration and FIFO behaviour are unchanged.

## Test plan
- Reset, then pipe_valid=1, pipe_addr=5, pipe_data=0x1234 for one cycle -> next cycle rf_write_enable=1, rf_write_address=5, rf_write_data=0x1234; following cycle rf_write_enable=0.
- issue_valid with issue_addr=7, then chk_addr1=7 -> hazard=1. LSU pushes {7, 0xCAFE} with pipeline idle -> write of x7=0xCAFE one cycle later; hazard=0 in that same cycle.
- Push 4 LSU entries while pipe_valid is held 1 -> lsu_ready=0 at fifo_count=4. After 4 pipeline wins, pipe_ready=0 for one cycle and the FIFO head is written; fifo_count=3, lsu_ready=1.
- pipe_valid with pipe_addr=0, then an LSU entry with addr 0 -> no rf_write_enable pulse for either; the FIFO still drains to fifo_count=0.
- issue_addr=9 set in the same cycle the FIFO writes x9 -> busy[9] remains 1; chk_addr2=9 gives hazard=1.
- Assert rst with fifo_count=2 and busy[3]=1 -> immediately fifo_count=0, hazard=0, rf_write_enable=0, lsu_ready=1.
